vdp_bg_renderer: RTL and testbench

Mode-4 background renderer on the VDP side of the display path. It answers the VGA wrapper's `row2vdp`/`col2vdp` pixel requests with a `pramOut` colour byte. Each 256-pixel SMS line is prefetched from VRAM into a double line buffer, with horizontal/vertical scroll and scroll inhibits applied. Sits between the VRAM/CRAM arbiter and `vga_wrapper`.

---
 rtl/vdp_pkg.sv | 44 ++++
 rtl/bg_line_buffer.sv | 34 +++
 rtl/vdp_bg_renderer.sv | 195 +++++++++++++++++++
 tb/tb_vdp_bg_renderer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared types, constants and scroll helpers for the mode-4 background renderer.
package vdp_pkg;

    localparam int unsigned SCREEN_W = 256;
    localparam int unsigned SCREEN_H = 192;
    localparam int unsigned BG_H     = 224;
    localparam logic [9:0]  NO_PIXEL = 10'h100;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       pri;
        logic       pal;
        logic       vflip;
        logic       hflip;
        logic [8:0] tile;
    } name_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NAME_LO,
        ST_NAME_HI,
        ST_PAT,
        ST_PIXEL
    } bg_state_t;

    // Background x for screen x; the top 16 lines may be pinned unscrolled.
    function automatic logic [7:0] bg_x(input logic [7:0] x, input logic [7:0] hscroll,
                                        input logic hinhib, input logic [8:0] line);
        if (hinhib && (line < 9'd16)) return x;
        return x - hscroll;
    endfunction

    // Background y, wrapped into the 224-line map; right 64 columns may be pinned.
    function automatic logic [7:0] bg_y(input logic [7:0] x, input logic [7:0] line,
                                        input logic [7:0] vscroll, input logic vinhib);
        logic [8:0] sum;
        if (vinhib && (x >= 8'd192)) return line;
        sum = 9'(line) + 9'(vscroll);
        if (sum >= 9'(BG_H)) sum = sum - 9'(BG_H);
        if (sum >= 9'(BG_H)) sum = sum - 9'(BG_H);
        return sum[7:0];
    endfunction

endpackage

// File: rtl/bg_line_buffer.sv
// Double 256x5 line buffer: fetch side writes one line while display reads the other.
module bg_line_buffer
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic       i_wsel,
    input  logic [7:0] i_wx,
    input  logic [4:0] i_wdata,
    input  logic       i_rsel,
    input  logic [7:0] i_rx,
    output logic [4:0] o_rdata
);

    localparam int unsigned DEPTH = SCREEN_W;

    logic [4:0] r_mem0 [DEPTH];
    logic [4:0] r_mem1 [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_wsel) r_mem1[i_wx] <= i_wdata;
            else        r_mem0[i_wx] <= i_wdata;
        end
    end

    // Registered read port doubles as the CRAM address register.
    always_ff @(posedge clk) begin
        if (!i_rst_n) o_rdata <= 5'd0;
        else          o_rdata <= i_rsel ? r_mem1[i_rx] : r_mem0[i_rx];
    end

endmodule

// File: rtl/vdp_bg_renderer.sv
// Mode-4 background renderer: prefetches each line from VRAM into a double
// line buffer and serves pixel requests through CRAM.
module vdp_bg_renderer
    import vdp_pkg::*;
#(
    parameter int unsigned VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               btnCpuReset,
    input  logic [9:0]         row2vdp,
    input  logic [9:0]         col2vdp,
    input  logic [7:0]         hScrollVal,
    input  logic [7:0]         vScrollVal,
    input  logic               hSInhib,
    input  logic               vSInhib,
    input  logic [3:0]         nameBase,
    output logic               vramReq,
    output logic [VRAM_AW-1:0] vramAddr,
    input  logic               vramAck,
    input  logic [7:0]         vramData,
    output logic [4:0]         cramAddr,
    input  logic [5:0]         cramData,
    output logic [7:0]         pramOut,
    output logic               fetchOverrun
);

    bg_state_t   r_state;
    logic [8:0]  r_line;
    logic [8:0]  r_last_line;
    logic        r_last_valid;
    logic [7:0]  r_x;
    logic [1:0]  r_plane;
    name_entry_t r_entry;
    logic [7:0]  r_planes [4];
    logic [7:0]  r_hscroll;
    logic [7:0]  r_vscroll;
    logic        r_hinhib;
    logic        r_vinhib;
    logic [2:0]  r_name_base;
    logic        r_vis1;
    logic        r_vis2;

    logic [8:0]  w_target;
    logic [7:0]  w_nx;
    logic [7:0]  w_bgx;
    logic [7:0]  w_bgy;
    logic [7:0]  w_nbgx;
    logic [7:0]  w_nbgy;
    logic        w_tile_change;
    logic [2:0]  w_pat_row;
    logic [2:0]  w_bit_idx;
    logic [3:0]  w_colour;
    logic [12:0] w_name_addr;
    logic [13:0] w_pat_addr;
    logic        w_abort;
    logic        w_unused_bits;

    assign w_target = (row2vdp[8:0] == NO_PIXEL[8:0]) ? 9'd0 : row2vdp[8:0] + 9'd1;
    assign w_abort  = (r_state != ST_IDLE) && (w_target != r_line);

    // Current pixel and its successor, so a tile change is known one cycle ahead.
    assign w_nx   = r_x + 8'd1;
    assign w_bgx  = bg_x(r_x,  r_hscroll, r_hinhib, r_line);
    assign w_bgy  = bg_y(r_x,  r_line[7:0], r_vscroll, r_vinhib);
    assign w_nbgx = bg_x(w_nx, r_hscroll, r_hinhib, r_line);
    assign w_nbgy = bg_y(w_nx, r_line[7:0], r_vscroll, r_vinhib);
    assign w_tile_change = {w_bgx[7:3], w_bgy} != {w_nbgx[7:3], w_nbgy};

    assign w_name_addr = {r_name_base, w_bgy[7:3], w_bgx[7:3]};
    assign w_pat_row   = r_entry.vflip ? (3'd7 - w_bgy[2:0]) : w_bgy[2:0];
    assign w_pat_addr  = {r_entry.tile, w_pat_row, r_plane};
    assign w_bit_idx   = r_entry.hflip ? w_bgx[2:0] : (3'd7 - w_bgx[2:0]);
    assign w_colour    = {r_planes[3][w_bit_idx], r_planes[2][w_bit_idx],
                          r_planes[1][w_bit_idx], r_planes[0][w_bit_idx]};

    assign w_unused_bits = ^{row2vdp[9], nameBase[0], r_entry.pri, r_entry.rsvd};

    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            r_state      <= ST_IDLE;
            vramReq      <= 1'b0;
            vramAddr     <= '0;
            fetchOverrun <= 1'b0;
            r_line       <= 9'd0;
            r_last_line  <= 9'd0;
            r_last_valid <= 1'b0;
            r_x          <= 8'd0;
            r_plane      <= 2'd0;
            r_entry      <= '0;
            r_hscroll    <= 8'd0;
            r_vscroll    <= 8'd0;
            r_hinhib     <= 1'b0;
            r_vinhib     <= 1'b0;
            r_name_base  <= 3'd0;
        end else begin
            fetchOverrun <= 1'b0;
            if (w_abort) begin
                fetchOverrun <= 1'b1;
                vramReq      <= 1'b0;
                vramAddr     <= '0;
                r_plane      <= 2'd0;
                r_state      <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if ((w_target != 9'(SCREEN_H)) &&
                            (!r_last_valid || (w_target != r_last_line))) begin
                            r_line      <= w_target;
                            r_x         <= 8'd0;
                            r_plane     <= 2'd0;
                            r_hscroll   <= hScrollVal;
                            r_vscroll   <= vScrollVal;
                            r_hinhib    <= hSInhib;
                            r_vinhib    <= vSInhib;
                            r_name_base <= nameBase[3:1];
                            r_state     <= ST_NAME_LO;
                        end
                    end
                    ST_NAME_LO: begin
                        if (!vramReq) begin
                            vramReq  <= 1'b1;
                            vramAddr <= VRAM_AW'({w_name_addr, 1'b0});
                        end else if (vramAck) begin
                            r_entry[7:0] <= vramData;
                            vramReq      <= 1'b0;
                            vramAddr     <= '0;
                            r_state      <= ST_NAME_HI;
                        end
                    end
                    ST_NAME_HI: begin
                        if (!vramReq) begin
                            vramReq  <= 1'b1;
                            vramAddr <= VRAM_AW'({w_name_addr, 1'b1});
                        end else if (vramAck) begin
                            r_entry[15:8] <= vramData;
                            vramReq       <= 1'b0;
                            vramAddr      <= '0;
                            r_plane       <= 2'd0;
                            r_state       <= ST_PAT;
                        end
                    end
                    ST_PAT: begin
                        if (!vramReq) begin
                            vramReq  <= 1'b1;
                            vramAddr <= VRAM_AW'(w_pat_addr);
                        end else if (vramAck) begin
                            r_planes[r_plane] <= vramData;
                            r_plane           <= r_plane + 2'd1;
                            vramReq           <= 1'b0;
                            vramAddr          <= '0;
                            if (r_plane == 2'd3) r_state <= ST_PIXEL;
                        end
                    end
                    ST_PIXEL: begin
                        r_x <= w_nx;
                        if (r_x == 8'(SCREEN_W - 1)) begin
                            r_last_line  <= r_line;
                            r_last_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (w_tile_change) begin
                            r_state <= ST_NAME_LO;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    bg_line_buffer u_line_buf (
        .clk     (clk),
        .i_rst_n (btnCpuReset),
        .i_we    (r_state == ST_PIXEL),
        .i_wsel  (r_line[0]),
        .i_wx    (r_x),
        .i_wdata ({r_entry.pal, w_colour}),
        .i_rsel  (row2vdp[0]),
        .i_rx    (col2vdp[7:0]),
        .o_rdata (cramAddr)
    );

    // Visibility follows the buffer read and CRAM read stages.
    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            r_vis1 <= 1'b0;
            r_vis2 <= 1'b0;
        end else begin
            r_vis1 <= (row2vdp[8:0] != NO_PIXEL[8:0]) && (col2vdp != NO_PIXEL);
            r_vis2 <= r_vis1;
        end
    end

    assign pramOut = r_vis2 ? {2'b00, cramData} : 8'h00;

endmodule

// File: tb/tb_vdp_bg_renderer.sv
// Directed bench for vdp_bg_renderer with VRAM/CRAM models and hand-computed pixels.
module tb_vdp_bg_renderer;

    logic        clk = 1'b0;
    logic        btnCpuReset;
    logic [9:0]  row2vdp, col2vdp;
    logic [7:0]  hScrollVal, vScrollVal;
    logic        hSInhib, vSInhib;
    logic [3:0]  nameBase;
    logic        vramReq;
    logic [13:0] vramAddr;
    logic        vramAck;
    logic [7:0]  vramData;
    logic [4:0]  cramAddr;
    logic [5:0]  cramData;
    logic [7:0]  pramOut;
    logic        fetchOverrun;

    logic [7:0]  vram [16384];
    logic [5:0]  cram [32];

    int n_checks = 0;
    int n_errors = 0;
    int max_wait = 0;
    bit stall    = 1'b0;
    int instab   = 0;
    int ovr_cnt  = 0;

    localparam int NB = 'h3800;

    always #5 clk = ~clk;

    vdp_bg_renderer #(.VRAM_AW(14)) dut (
        .clk          (clk),
        .btnCpuReset  (btnCpuReset),
        .row2vdp      (row2vdp),
        .col2vdp      (col2vdp),
        .hScrollVal   (hScrollVal),
        .vScrollVal   (vScrollVal),
        .hSInhib      (hSInhib),
        .vSInhib      (vSInhib),
        .nameBase     (nameBase),
        .vramReq      (vramReq),
        .vramAddr     (vramAddr),
        .vramAck      (vramAck),
        .vramData     (vramData),
        .cramAddr     (cramAddr),
        .cramData     (cramData),
        .pramOut      (pramOut),
        .fetchOverrun (fetchOverrun)
    );

    // VRAM responder with optional random wait states and a stall switch.
    initial begin
        int wcnt;
        wcnt     = 0;
        vramAck  = 1'b0;
        vramData = 8'h00;
        forever begin
            @(negedge clk);
            if (vramReq && !stall) begin
                if (wcnt == 0) begin
                    vramAck  = 1'b1;
                    vramData = vram[vramAddr];
                end else begin
                    vramAck = 1'b0;
                    wcnt--;
                end
            end else begin
                vramAck = 1'b0;
                wcnt    = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
            end
        end
    end

    // Synchronous CRAM, one cycle read.
    initial begin
        cramData = 6'd0;
        forever begin
            @(posedge clk);
            cramData <= cram[cramAddr];
        end
    end

    // Address stability and overrun pulse monitor.
    initial begin
        logic        prev_req;
        logic [13:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (btnCpuReset && prev_req && vramReq && (vramAddr != prev_addr)) instab++;
            if (fetchOverrun) ovr_cnt++;
            prev_req  = vramReq;
            prev_addr = vramAddr;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [9:0] r, input logic [9:0] c,
                       output logic [4:0] ca, output logic [7:0] p);
        @(negedge clk);
        row2vdp = r;
        col2vdp = c;
        @(negedge clk);
        ca = cramAddr;
        @(negedge clk);
        p = pramOut;
    endtask

    task automatic check_pix(input string tag, input logic [9:0] r, input logic [9:0] c,
                             input int exp);
        logic [4:0] ca;
        logic [7:0] p;
        pix(r, c, ca, p);
        check_val(tag, int'(p), exp);
    endtask

    // Reset, program scroll state, then let line `row` fetch into its buffer.
    task automatic render(input int row, input logic [7:0] h, input logic [7:0] v,
                          input logic hi, input logic vi, input int mw);
        @(negedge clk);
        btnCpuReset = 1'b0;
        hScrollVal  = h;
        vScrollVal  = v;
        hSInhib     = hi;
        vSInhib     = vi;
        max_wait    = mw;
        row2vdp     = (row == 0) ? 10'h100 : 10'(row - 1);
        col2vdp     = 10'h100;
        repeat (2) @(negedge clk);
        btnCpuReset = 1'b1;
        repeat (2000) @(negedge clk);
    endtask

    initial begin
        logic [4:0] ca;
        logic [7:0] p;
        int         ovr0;

        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        for (int i = 0; i < 32; i++) cram[i] = 6'h00;
        cram[0] = 6'h2A; cram[1] = 6'h03; cram[2] = 6'h0C; cram[3] = 6'h07;
        cram[4] = 6'h30; cram[8] = 6'h15; cram[16] = 6'h11; cram[17] = 6'h3F;

        vram[NB + 0]   = 8'h01;   // (0,0)  -> tile 1
        vram[NB + 62]  = 8'h02;   // (0,31) -> tile 2
        vram[NB + 114] = 8'h03;   // (1,25) -> tile 3
        vram[32 + 0]   = 8'hFF;   // tile 1 row 0 plane 0
        vram[32 + 22]  = 8'hF0;   // tile 1 row 5 plane 2
        vram[32 + 27]  = 8'hFF;   // tile 1 row 6 plane 3
        vram[64 + 1]   = 8'hFF;   // tile 2 row 0 plane 1
        vram[96 + 8]   = 8'hFF;   // tile 3 row 2 plane 0
        vram[96 + 9]   = 8'hFF;   // tile 3 row 2 plane 1
        vram[128 + 28] = 8'h80;   // tile 4 row 7 plane 0

        btnCpuReset = 1'b0;
        row2vdp = 10'h100; col2vdp = 10'h100;
        hScrollVal = 8'd0; vScrollVal = 8'd0; hSInhib = 1'b0; vSInhib = 1'b0;
        nameBase = 4'hE;
        repeat (3) @(negedge clk);
        check_val("rst_req",  int'(vramReq), 0);
        check_val("rst_addr", int'(vramAddr), 0);
        check_val("rst_cram", int'(cramAddr), 0);
        check_val("rst_pram", int'(pramOut), 0);
        check_val("rst_ovr",  int'(fetchOverrun), 0);

        // Zero scroll
        render(0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
        for (int c = 0; c < 8; c++) check_pix($sformatf("zs_col%0d", c), 10'd0, 10'(c), 'h03);
        check_pix("zs_col8", 10'd0, 10'd8, 'h2A);
        pix(10'd0, 10'd0, ca, p);
        check_val("zs_cram_addr", int'(ca), 1);
        check_pix("off_row", 10'h100, 10'd3, 'h00);
        check_pix("off_col", 10'd0, 10'h100, 'h00);

        // Horizontal scroll and inhibit
        render(0, 8'd3, 8'd0, 1'b0, 1'b0, 0);
        check_pix("hs_x0",  10'd0, 10'd0,  'h0C);
        check_pix("hs_x2",  10'd0, 10'd2,  'h0C);
        check_pix("hs_x3",  10'd0, 10'd3,  'h03);
        check_pix("hs_x10", 10'd0, 10'd10, 'h03);
        check_pix("hs_x11", 10'd0, 10'd11, 'h2A);
        render(5, 8'd3, 8'd0, 1'b0, 1'b0, 0);
        check_pix("r5_scr_x0", 10'd5, 10'd0, 'h2A);
        check_pix("r5_scr_x3", 10'd5, 10'd3, 'h30);
        render(5, 8'd3, 8'd0, 1'b1, 1'b0, 0);
        check_pix("r5_inh_x0", 10'd5, 10'd0, 'h30);
        check_pix("r5_inh_x3", 10'd5, 10'd3, 'h30);
        check_pix("r5_inh_x4", 10'd5, 10'd4, 'h2A);

        // Vertical scroll and inhibit
        render(10, 8'd0, 8'd220, 1'b0, 1'b0, 0);
        check_pix("vs_x0",   10'd10, 10'd0,   'h15);
        check_pix("vs_x200", 10'd10, 10'd200, 'h2A);
        render(10, 8'd0, 8'd220, 1'b0, 1'b1, 0);
        check_pix("vi_x0",   10'd10, 10'd0,   'h15);
        check_pix("vi_x191", 10'd10, 10'd191, 'h2A);
        check_pix("vi_x200", 10'd10, 10'd200, 'h07);

        // Flips and palette
        vram[NB + 0] = 8'h04;
        vram[NB + 1] = 8'h0E;
        render(0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
        pix(10'd0, 10'd7, ca, p);
        check_val("flip_x7_addr", int'(ca), 17);
        check_val("flip_x7_pram", int'(p), 'h3F);
        pix(10'd0, 10'd0, ca, p);
        check_val("flip_x0_addr", int'(ca), 16);
        check_val("flip_x0_pram", int'(p), 'h11);

        // Random wait states, same expected pixels as the zero-wait scroll case
        vram[NB + 0] = 8'h01;
        vram[NB + 1] = 8'h00;
        render(0, 8'd3, 8'd0, 1'b0, 1'b0, 5);
        check_pix("ws_x0",  10'd0, 10'd0,  'h0C);
        check_pix("ws_x3",  10'd0, 10'd3,  'h03);
        check_pix("ws_x10", 10'd0, 10'd10, 'h03);
        check_pix("ws_x11", 10'd0, 10'd11, 'h2A);
        check_val("addr_stable", instab, 0);

        // Overrun: stall VRAM, advance the row
        @(negedge clk);
        btnCpuReset = 1'b0;
        stall = 1'b1;
        max_wait = 0;
        hScrollVal = 8'd0;
        row2vdp = 10'h100;
        col2vdp = 10'h100;
        repeat (2) @(negedge clk);
        btnCpuReset = 1'b1;
        repeat (50) @(negedge clk);
        check_val("stall_req",  int'(vramReq), 1);
        check_val("stall_addr", int'(vramAddr), NB);
        ovr0 = ovr_cnt;
        row2vdp = 10'd0;
        repeat (10) @(negedge clk);
        check_val("ovr_pulses",  ovr_cnt - ovr0, 1);
        check_val("restart_req", int'(vramReq), 1);

        // Reset while a request is outstanding
        btnCpuReset = 1'b0;
        @(negedge clk);
        check_val("mrst_req",  int'(vramReq), 0);
        check_val("mrst_addr", int'(vramAddr), 0);
        check_val("mrst_cram", int'(cramAddr), 0);
        check_val("mrst_pram", int'(pramOut), 0);
        check_val("mrst_ovr",  int'(fetchOverrun), 0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        btnCpuReset = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
